// File: rtl/tcdm_mem_model.sv
// Simulation memory model: MP request/grant ports sharing one word array, 1-cycle responses.
// Optional macro TCDM_RANDOM_STALL_EN adds per-port LFSR-driven random grant stalls.
module tcdm_mem_model #(
  parameter int unsigned MP          = 1,
  parameter logic [31:0] MEMORY_SIZE = 32'h30000,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned PROB_STALL  = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [MP-1:0]       tcdm_req_i,
  output logic [MP-1:0]       tcdm_gnt_o,
  input  logic [MP-1:0][31:0] tcdm_add_i,
  input  logic [MP-1:0]       tcdm_wen_i,
  input  logic [MP-1:0][3:0]  tcdm_be_i,
  input  logic [MP-1:0][31:0] tcdm_data_i,
  output logic [MP-1:0][31:0] tcdm_r_data_o,
  output logic [MP-1:0]       tcdm_r_valid_o
);

  localparam int unsigned WORDS = MEMORY_SIZE / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0]              memory [WORDS];
  logic [MP-1:0][IDX_W-1:0] idx;
  logic [MP-1:0]            gnt;
  logic [MP-1:0]            r_valid_q;
  logic [MP-1:0][31:0]      r_data_q;

  // Out-of-range addresses wrap silently; the low two address bits drop out.
  always_comb begin
    idx = '0;
    for (int i = 0; i < MP; i++) begin
      idx[i] = IDX_W'(((tcdm_add_i[i] - BASE_ADDR) % MEMORY_SIZE) >> 2);
    end
  end

`ifdef TCDM_RANDOM_STALL_EN
  logic [MP-1:0][15:0] lfsr_q;
  logic [MP-1:0]       stall;

  // Fibonacci LFSR, taps 16,14,13,11; per-port seed keeps the ports decorrelated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MP; i++) begin
        lfsr_q[i] <= 16'(i + 1);
      end
    end else begin
      for (int i = 0; i < MP; i++) begin
        lfsr_q[i] <= {lfsr_q[i][14:0],
                      lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
      end
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stall = '0;
    for (int i = 0; i < MP; i++) begin
      stall[i] = ((32'(lfsr_q[i]) % 32'd100) < PROB_STALL);
    end
  end

  assign gnt = tcdm_req_i & {MP{enable_i}} & ~stall;
`else
  assign gnt = tcdm_req_i & {MP{enable_i}};
`endif

  // NOTE: the storage array has no reset branch; preloaded contents must survive rst_ni.
  // Non-blocking writes in ascending port order let the highest port win each byte.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (gnt[i] && !tcdm_wen_i[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm_be_i[i][b]) begin
            memory[idx[i]][8*b +: 8] <= tcdm_data_i[i][8*b +: 8];
          end
        end
      end
    end
  end

  // NOTE: non-blocking reads here sample memory before this edge's writes land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      for (int i = 0; i < MP; i++) begin
        r_valid_q[i] <= gnt[i];
        if (gnt[i]) begin
          r_data_q[i] <= memory[idx[i]];
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;

endmodule

// File: tb/tb_tcdm_mem_model.sv
// Directed bench for tcdm_mem_model: reference model plus per-port response scoreboard.
module tb_tcdm_mem_model;

  localparam int          MP   = 3;
  localparam int          NQ   = 5;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [31:0] SIZE = 32'h0003_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  logic [MP-1:0]       req, gnt, wen, r_valid;
  logic [MP-1:0][31:0] add, data, r_data;
  logic [MP-1:0][3:0]  be;

  logic        w_req, w_gnt, w_wen, w_r_valid;
  logic [31:0] w_add, w_data, w_r_data;
  logic [3:0]  w_be;

  logic        s_req, s_gnt, s_r_valid;
  logic [31:0] s_add, s_r_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q [NQ][$];
  logic [31:0] model   [int];
  logic [31:0] model_w [int];

  logic [NQ-1:0] vld;
  logic [31:0]   rdat [NQ];

  tcdm_mem_model #(.MP(MP), .MEMORY_SIZE(SIZE), .BASE_ADDR(BASE), .PROB_STALL(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(data), .tcdm_r_data_o(r_data), .tcdm_r_valid_o(r_valid)
  );

  tcdm_mem_model #(.MP(1), .MEMORY_SIZE(SIZE), .BASE_ADDR(32'h0), .PROB_STALL(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .tcdm_req_i(w_req), .tcdm_gnt_o(w_gnt), .tcdm_add_i(w_add), .tcdm_wen_i(w_wen),
    .tcdm_be_i(w_be), .tcdm_data_i(w_data), .tcdm_r_data_o(w_r_data), .tcdm_r_valid_o(w_r_valid)
  );

`ifdef TCDM_RANDOM_STALL_EN
  tcdm_mem_model #(.MP(1), .MEMORY_SIZE(32'h100), .BASE_ADDR(32'h0), .PROB_STALL(50)) u_stall (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(1'b1),
    .tcdm_req_i(s_req), .tcdm_gnt_o(s_gnt), .tcdm_add_i(s_add), .tcdm_wen_i(1'b1),
    .tcdm_be_i(4'hF), .tcdm_data_i(32'h0), .tcdm_r_data_o(s_r_data), .tcdm_r_valid_o(s_r_valid)
  );
`else
  assign s_gnt     = 1'b0;
  assign s_r_valid = 1'b0;
  assign s_r_data  = 32'h0;
`endif

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      vld[p]  = r_valid[p];
      rdat[p] = r_data[p];
    end
    vld[3]  = w_r_valid;
    rdat[3] = w_r_data;
    vld[4]  = s_r_valid;
    rdat[4] = s_r_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a, input logic [31:0] base);
    return int'(((a - base) % SIZE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input int k);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  function automatic logic [31:0] mread_w(input int k);
    return model_w.exists(k) ? model_w[k] : 32'h0;
  endfunction

  // Scoreboard: every response popped in order per port; stray responses are failures.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NQ; p++) begin
        if (vld[p]) begin
          if (exp_q[p].size() == 0) check($sformatf("stray_rvalid_p%0d", p), 32'(vld[p]), 32'h0);
          else check($sformatf("rdata_p%0d", p), rdat[p], exp_q[p].pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge with inputs set; returns #1 after the accepting edge.
  task automatic step();
    logic [31:0] pre [MP];
    int k;
    #1;
    for (int p = 0; p < MP; p++)
      check($sformatf("gnt_p%0d", p), 32'(gnt[p]), 32'(req[p] & en));
    check("gnt_wrap", 32'(w_gnt), 32'(w_req & en));
    for (int p = 0; p < MP; p++) pre[p] = mread(idx_of(add[p], BASE));
    for (int p = 0; p < MP; p++) begin
      if (req[p] && en) begin
        k = idx_of(add[p], BASE);
        exp_q[p].push_back(pre[p]);
        if (!wen[p]) model[k] = merge(mread(k), data[p], be[p]);
      end
    end
    if (w_req && en) begin
      k = idx_of(w_add, 32'h0);
      exp_q[3].push_back(mread_w(k));
      if (!w_wen) model_w[k] = merge(mread_w(k), w_data, w_be);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = '0;
    w_req = 1'b0;
    step();
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    req[p]  = 1'b1;
    wen[p]  = w;
    add[p]  = a;
    data[p] = d;
    be[p]   = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1;
    req = '0; wen = '1; add = '0; data = '0; be = '0;
    w_req = 1'b0; w_wen = 1'b1; w_add = '0; w_data = '0; w_be = '0;
    s_req = 1'b0; s_add = '0;

    u_dut.memory[0]         = 32'hDEADBEEF; model[0]       = 32'hDEADBEEF;
    u_dut.memory[5]         = 32'hAAAAAAAA; model[5]       = 32'hAAAAAAAA;
    u_dut.memory[7]         = 32'h12345678; model[7]       = 32'h12345678;
    u_wrap.memory[32'h8000] = 32'h5A5A5A5A; model_w[32'h8000] = 32'h5A5A5A5A;
`ifdef TCDM_RANDOM_STALL_EN
    for (int i = 0; i < 8; i++) u_stall.memory[i] = 32'(i) * 32'h01010101;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", 32'(r_valid), 32'h0);
    check("reset_rdata0", r_data[0], 32'h0);
    check("reset_rdata2", r_data[2], 32'h0);
    check("reset_rvalid_wrap", 32'(w_r_valid), 32'h0);
    rst_n = 1'b1;

    // Preloaded read
    set_port(0, 1'b1, BASE, 32'h0, 4'h0);
    step();
    check("preload_rvalid", 32'(r_valid[0]), 32'h1);
    check("preload_rdata", r_data[0], 32'hDEADBEEF);

    // Byte-enable write then read back, then idle hold
    set_port(0, 1'b0, BASE + 32'h14, 32'h11223344, 4'b0101);
    step();
    check("bytewr_rvalid", 32'(r_valid[0]), 32'h1);
    set_port(0, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
    step();
    check("byte_merge", r_data[0], 32'hAA22AA44);
    idle();
    check("idle_rvalid", 32'(r_valid), 32'h0);
    check("rdata_hold", r_data[0], 32'hAA22AA44);

    // Multi-port same-word conflict
    set_port(0, 1'b0, BASE + 32'h1C, 32'h00000000, 4'hF);
    set_port(1, 1'b0, BASE + 32'h1D, 32'hFFFFFFFF, 4'hF);
    set_port(2, 1'b1, BASE + 32'h1C, 32'h0, 4'h0);
    step();
    check("conflict_read_old", r_data[2], 32'h12345678);
    req = '0;
    set_port(0, 1'b1, BASE + 32'h1C, 32'h0, 4'h0);
    step();
    check("conflict_winner", r_data[0], 32'hFFFFFFFF);

    // Back-to-back pipelined reads on two ports
    req = '0;
    set_port(0, 1'b1, BASE,          32'h0, 4'h0);
    set_port(1, 1'b1, BASE + 32'h1C, 32'h0, 4'h0);
    step();
    set_port(0, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
    set_port(1, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
    step();
    set_port(0, 1'b1, BASE + 32'h1C, 32'h0, 4'h0);
    set_port(1, 1'b1, BASE,          32'h0, 4'h0);
    step();
    check("pipe_rvalid", 32'(r_valid[1:0]), 32'h3);
    idle();

    // Address wrap on the BASE_ADDR = 0 instance
    w_req = 1'b1; w_wen = 1'b0; w_add = 32'h0014_0000; w_data = 32'hCAFEF00D; w_be = 4'hF;
    step();
    w_wen = 1'b1; w_add = 32'h0002_0000;
    step();
    check("wrap_rdata", w_r_data, 32'hCAFEF00D);
    idle();

    // Enable gating: in-flight response completes, gated requests do nothing
    set_port(0, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
    step();
    en = 1'b0;
    set_port(0, 1'b0, BASE, 32'h0, 4'hF);
    set_port(1, 1'b1, BASE, 32'h0, 4'h0);
    w_req = 1'b1; w_wen = 1'b0; w_data = 32'h0;
    step();
    check("gated_rvalid", 32'(r_valid), 32'h0);
    check("gated_rvalid_wrap", 32'(w_r_valid), 32'h0);
    en = 1'b1;
    req = '0; w_req = 1'b0;
    set_port(0, 1'b1, BASE, 32'h0, 4'h0);
    step();
    check("gated_mem_kept", r_data[0], 32'hDEADBEEF);

    // Asynchronous reset mid-burst
    set_port(0, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
    set_port(1, 1'b1, BASE + 32'h1C, 32'h0, 4'h0);
    set_port(2, 1'b1, BASE,          32'h0, 4'h0);
    step();
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_rvalid_drop", 32'(r_valid), 32'h0);
    check("rst_rdata_clear", r_data[1], 32'h0);
    for (int p = 0; p < NQ; p++) exp_q[p].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check("rst_no_response", 32'(r_valid), 32'h0);
    set_port(0, 1'b1, BASE, 32'h0, 4'h0);
    step();
    check("rst_preload_kept", r_data[0], 32'hDEADBEEF);
    idle();

`ifdef TCDM_RANDOM_STALL_EN
    begin : stall_test
      int grants;
      int cycles;
      int waited;
      grants = 0;
      cycles = 0;
      for (int n = 0; n < 1000; n++) begin
        s_req  = 1'b1;
        s_add  = 32'(4 * (n % 8));
        waited = 0;
        #1;
        while (!s_gnt && waited < 200) begin
          @(posedge clk);
          #2;
          waited++;
        end
        cycles += waited + 1;
        if (s_gnt) begin
          exp_q[4].push_back(32'(n % 8) * 32'h01010101);
          grants++;
        end else begin
          check("stall_timeout", 32'(s_gnt), 32'h1);
        end
        @(posedge clk);
        #1;
      end
      s_req = 1'b0;
      check("stall_grants", 32'(grants), 32'd1000);
      check("stall_rate", 32'((grants * 100 >= 40 * cycles) && (grants * 100 <= 60 * cycles)), 32'h1);
    end
`endif

    idle();
    idle();
    for (int p = 0; p < NQ; p++)
      check($sformatf("pending_p%0d", p), 32'(exp_q[p].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
